// File: rtl/frame_stream_reader.sv
// Raster-scan frame-buffer reader feeding filter_unit: flush, read, zero-pad drain, done.
// Optional top border row of zero pixels when FRAME_STREAM_READER_TOP_PAD_EN is defined.
module frame_stream_reader #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned OPE_LATENCY  = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [31:0]       i_image_width,
    input  logic [31:0]       i_image_height,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [8:0]        i_mem_data,
    output logic [8:0]        o_pix_out,
    output logic              o_pix_valid,
    output logic              o_reflesh,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef FRAME_STREAM_READER_TOP_PAD_EN
    localparam logic [2:0] ST_TOPPAD = 3'd2;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [31:0]       r_width;
    logic [31:0]       r_height;
    logic [31:0]       r_cnt;
    logic [31:0]       r_x;
    logic [31:0]       r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_dly;
    logic              r_pv;

    logic              w_accept;
    logic              w_empty;
    logic              w_last_px;
    logic [31:0]       w_drain_len;
    logic              w_pad;

    assign w_accept    = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_empty     = (r_width == 32'd0) || (r_height == 32'd0);
    assign w_last_px   = (r_x == r_width - 32'd1) && (r_y == r_height - 32'd1);
    assign w_drain_len = r_width + 32'(OPE_LATENCY) + 32'd1;

    // Pads are issued one cycle ahead of their output, like reads, so they line up
    // with the read data path; the final DRAIN cycle issues nothing.
    always_comb begin
        w_pad = (r_state == ST_DRAIN) && (r_cnt != w_drain_len);
`ifdef FRAME_STREAM_READER_TOP_PAD_EN
        if (r_state == ST_TOPPAD) begin
            w_pad = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 32'(FLUSH_CYCLES - 1)) begin
                    if (w_empty) begin
                        w_state_nxt = ST_DONE;
                    end else begin
`ifdef FRAME_STREAM_READER_TOP_PAD_EN
                        w_state_nxt = ST_TOPPAD;
`else
                        w_state_nxt = ST_READ;
`endif
                    end
                end
            end
`ifdef FRAME_STREAM_READER_TOP_PAD_EN
            ST_TOPPAD: begin
                if (r_cnt == r_width - 32'd1) begin
                    w_state_nxt = ST_READ;
                end
            end
`endif
            ST_READ: begin
                if (w_last_px) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == w_drain_len) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_width  <= 32'd0;
            r_height <= 32'd0;
            r_cnt    <= 32'd0;
            r_x      <= 32'd0;
            r_y      <= 32'd0;
            r_addr   <= '0;
            r_rd_dly <= 1'b0;
            r_pv     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_width  <= i_image_width;
                r_height <= i_image_height;
            end
            if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (r_state == ST_READ) begin
                r_addr <= r_addr + 1'b1;
                if (r_x == r_width - 32'd1) begin
                    r_x <= 32'd0;
                    r_y <= r_y + 32'd1;
                end else begin
                    r_x <= r_x + 32'd1;
                end
            end else if (r_state == ST_IDLE) begin
                r_addr <= '0;
                r_x    <= 32'd0;
                r_y    <= 32'd0;
            end
            r_rd_dly <= o_mem_rd && !i_abort;
            r_pv     <= (o_mem_rd || w_pad) && !i_abort;
        end
    end

    assign o_mem_rd    = (r_state == ST_READ);
    assign o_mem_addr  = r_addr;
    assign o_pix_out   = r_rd_dly ? i_mem_data : 9'd0;
    assign o_pix_valid = r_pv;
    assign o_reflesh   = (r_state == ST_FLUSH);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench for frame_stream_reader: per-busy-cycle tokens queued from directed
// frames, compared by a negedge monitor. Define FRAME_STREAM_READER_TOP_PAD_EN to cover TOPPAD.
module tb_frame_stream_reader;

    localparam int FL  = 2;
    localparam int OPE = 2;
`ifdef FRAME_STREAM_READER_TOP_PAD_EN
    localparam bit TOP_PAD = 1'b1;
`else
    localparam bit TOP_PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] width = 32'd0;
    logic [31:0] height = 32'd0;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic [8:0]  mem_data = 9'd0;
    logic [8:0]  pix_out;
    logic        pix_valid;
    logic        reflesh;
    logic        busy;
    logic        done;

    logic [15:0] exp_q[$];
    logic [15:0] mon_tok;
    logic [15:0] mon_exp;
    bit          sb_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    frame_stream_reader dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_image_width  (width),
        .i_image_height (height),
        .o_mem_rd       (mem_rd),
        .o_mem_addr     (mem_addr),
        .i_mem_data     (mem_data),
        .o_pix_out      (pix_out),
        .o_pix_valid    (pix_valid),
        .o_reflesh      (reflesh),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // RAM[i] = i (9-bit), one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[8:0];
    end

    // Token: {reflesh, done, pix_valid, mem_rd, 3'b0, pixel}
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            checks++;
            if (busy) begin
                mon_tok = {reflesh, done, pix_valid, mem_rd, 3'b000,
                           (pix_valid ? pix_out : 9'd0)};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: got token %h while busy, expected none", mon_tok);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_tok !== mon_exp) begin
                        errors++;
                        $display("FAIL stream @%0t: got token %h, expected %h",
                                 $time, mon_tok, mon_exp);
                    end
                end
            end else if (mem_rd || pix_valid || reflesh || done) begin
                errors++;
                $display("FAIL idle_outputs: rd=%b pv=%b ref=%b done=%b, expected all 0",
                         mem_rd, pix_valid, reflesh, done);
            end
        end
    end

    task automatic push_exp(input int w, input int h, input int cutoff);
        int tp, r0, wh, n, len;
        logic [15:0] tok;
        if (w == 0 || h == 0) begin
            for (int k = 0; k <= FL; k++) begin
                tok = (k < FL) ? 16'h8000 : 16'h4000;
                if (cutoff < 0 || k < cutoff) exp_q.push_back(tok);
            end
        end else begin
            tp  = TOP_PAD ? w : 0;
            r0  = FL + tp;
            wh  = w * h;
            n   = w + 1 + OPE;
            len = r0 + wh + n + 2;
            for (int k = 0; k < len; k++) begin
                tok = 16'h0000;
                if (k < FL) tok[15] = 1'b1;
                if (k >= r0 && k < r0 + wh) tok[12] = 1'b1;
                if (k >= r0 + 1 && k <= r0 + wh) begin
                    tok[13]  = 1'b1;
                    tok[8:0] = 9'((k - r0 - 1) % 512);
                end
                if (k >= FL + 1 && k <= FL + tp) tok[13] = 1'b1;
                if (k > r0 + wh && k <= r0 + wh + n) tok[13] = 1'b1;
                if (k == len - 1) tok[14] = 1'b1;
                if (cutoff < 0 || k < cutoff) exp_q.push_back(tok);
            end
        end
    endtask

    // Returns during the first busy cycle (idx0), 1 ns after the accepting edge
    task automatic start_frame(input int w, input int h);
        @(posedge clk);
        #1;
        start  = 1'b1;
        width  = 32'(w);
        height = 32'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b, expected 0 within 2000 cycles", name, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d tokens not seen, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (mem_rd || pix_valid || busy || reflesh || done || pix_out != 9'd0) begin
            errors++;
            $display("FAIL %s: rd=%b pv=%b busy=%b ref=%b done=%b pix=%0d, expected all 0",
                     name, mem_rd, pix_valid, busy, reflesh, done, pix_out);
        end
    endtask

    initial begin
        int r0;
        r0 = FL + (TOP_PAD ? 4 : 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_state");
        @(negedge clk);
        rst = 1'b0;
        sb_en = 1'b1;

        // Asynchronous reset in the middle of READ
        sb_en = 1'b0;
        start_frame(4, 3);
        repeat (r0 + 2) @(posedge clk);
        #2;
        checks++;
        if (!mem_rd) begin
            errors++;
            $display("FAIL rst_precond: mem_rd=%b, expected 1", mem_rd);
        end
        rst = 1'b1;
        #1;
        check_quiet("rst_async");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        sb_en = 1'b1;

        // Basic 4x3 frame
        push_exp(4, 3, -1);
        start_frame(4, 3);
        wait_idle("frame_4x3");

        // Zero width
        push_exp(0, 5, -1);
        start_frame(0, 5);
        wait_idle("frame_0x5");

        // start and abort together in IDLE: abort wins
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        width = 32'd4;
        height = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b, expected 0", busy);
        end
        repeat (2) @(posedge clk);

        // start re-pulsed mid-frame with different size: ignored
        push_exp(4, 3, -1);
        start_frame(4, 3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        width = 32'd2;
        height = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("restart_ignored");

        // Abort on the 6th pixel, then a normal 2x2 frame
        push_exp(4, 3, r0 + 7);
        start_frame(4, 3);
        repeat (r0 + 6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy || mem_rd || pix_valid || done) begin
            errors++;
            $display("FAIL abort_next: busy=%b rd=%b pv=%b done=%b, expected all 0",
                     busy, mem_rd, pix_valid, done);
        end
        wait_idle("abort");
        push_exp(2, 2, -1);
        start_frame(2, 2);
        wait_idle("frame_2x2");

`ifdef FRAME_STREAM_READER_TOP_PAD_EN
        push_exp(4, 2, -1);
        start_frame(4, 2);
        wait_idle("toppad_4x2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
